// File: rtl/gpr_ctrl_pkg.sv
// Shared definitions for the general-purpose register file write-side control.
// Contents:
//   DATA_W, ADDR_W, NUM_REGS  register file geometry (32 x 32)
//   ZERO_REG                  hardwired-zero register address
//   wb_req_t                  one writeback request (valid, addr, data)
package gpr_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, reset  clock and synchronous active-high reset (pointer -> requester 0)
//   req[1:0]    request lines
//   grant[1:0]  one-hot grant, combinational from req and the pointer;
//               never asserts a bit whose request is low
// A lone requester is always granted. On contention the pointer picks the
// winner; after every grant the pointer moves to the other requester.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 0: requester 0 wins the next tie, 1: requester 1 wins it
    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            // after granting 0 point at 1, after granting 1 point at 0
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/gpr_wb_scheduler.sv
// Write-port scheduler and pending-write scoreboard for the 32x32 GPR file.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rsv_valid/rsv_addr/rsv_ready    destination reservation from issue
//   srcN_valid/addr/data/ready      writeback requests (N=0 ALU, N=1 load)
//   query_a_addr, query_b_addr      read addresses presented to the file
//   hazard                          either queried register is pending
//   gpr_we, gpr_addr, gpr_data      registered write port to the file
//   busy                            pending-write scoreboard, bit 0 always 0
//   wb_err                          sticky: writeback to a non-pending register
module gpr_wb_scheduler
    import gpr_ctrl_pkg::*;
#(
    parameter int DATA_W = gpr_ctrl_pkg::DATA_W,
    parameter int ADDR_W = gpr_ctrl_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ready,
    input  logic                     src0_valid,
    input  logic [ADDR_W-1:0]        src0_addr,
    input  logic [DATA_W-1:0]        src0_data,
    output logic                     src0_ready,
    input  logic                     src1_valid,
    input  logic [ADDR_W-1:0]        src1_addr,
    input  logic [DATA_W-1:0]        src1_data,
    output logic                     src1_ready,
    input  logic [ADDR_W-1:0]        query_a_addr,
    input  logic [ADDR_W-1:0]        query_b_addr,
    output logic                     hazard,
    output logic                     gpr_we,
    output logic [ADDR_W-1:0]        gpr_addr,
    output logic [DATA_W-1:0]        gpr_data,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     wb_err
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]      grant;
    wb_req_t         req0;
    wb_req_t         req1;
    wb_req_t         sel_p0;
    logic            rsv_fire;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;
    logic            we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic            err_q;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({src1_valid, src0_valid}),
        .grant (grant)
    );

    assign src0_ready = grant[0];
    assign src1_ready = grant[1];

    // r0 is never marked busy, so reserving it is always accepted
    assign rsv_ready = ~busy_q[rsv_addr];
    assign rsv_fire  = rsv_valid & rsv_ready;

    assign hazard = busy_q[query_a_addr] | busy_q[query_b_addr];

    // ---- stage p0: select the granted writeback ----
    always_comb begin
        req0   = '{valid: src0_valid, addr: src0_addr, data: src0_data};
        req1   = '{valid: src1_valid, addr: src1_addr, data: src1_data};
        sel_p0 = grant[1] ? req1 : req0;
        sel_p0.valid = |grant;
    end

    // The clear for the register being written and the set for a new
    // reservation can never hit the same bit: that reservation is refused
    // while the bit is still set.
    always_comb begin
        busy_next = busy_q;
        if (we_p1) begin
            busy_next[addr_p1] = 1'b0;
        end
        if (rsv_fire && rsv_addr != ZERO_REG) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // ---- stage p1: registered write port, scoreboard, error flag ----
    always_ff @(posedge clk) begin
        if (reset) begin
            we_p1   <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // writes to r0 are consumed but never reach the file
            we_p1  <= sel_p0.valid && (sel_p0.addr != ZERO_REG);
            busy_q <= busy_next;
            if (sel_p0.valid) begin
                addr_p1 <= sel_p0.addr;
                data_p1 <= sel_p0.data;
                if (sel_p0.addr != ZERO_REG && !busy_q[sel_p0.addr]) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign gpr_we   = we_p1;
    assign gpr_addr = addr_p1;
    assign gpr_data = data_p1;
    assign busy     = busy_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Self-checking bench for gpr_wb_scheduler: directed scenarios plus a
// randomized run checked against a behavioural model (scoreboard as a bit
// array, "preferred source" for ties, one pending file write).
module tb_gpr_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rsv_valid, rsv_ready;
    logic [4:0]  rsv_addr;
    logic        src0_valid, src0_ready, src1_valid, src1_ready;
    logic [4:0]  src0_addr, src1_addr;
    logic [31:0] src0_data, src1_data;
    logic [4:0]  query_a_addr, query_b_addr;
    logic        hazard, gpr_we, wb_err;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;
    logic [31:0] busy;

    int checks = 0;
    int failures = 0;

    // register file fed by the DUT write port
    logic [31:0] file_mem [32];

    // reference model state
    bit          mbusy [32];
    int          pref = 0;
    bit          mwe = 0;
    logic [4:0]  maddr = '0;
    logic [31:0] mdata = '0;
    bit          merr = 0;

    gpr_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_addr(src1_addr), .src1_data(src1_data), .src1_ready(src1_ready),
        .query_a_addr(query_a_addr), .query_b_addr(query_b_addr), .hazard(hazard),
        .gpr_we(gpr_we), .gpr_addr(gpr_addr), .gpr_data(gpr_data),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gpr_we) file_mem[gpr_addr] <= gpr_data;
    end

    function automatic logic [1:0] exp_grant();
        if (src0_valid && src1_valid) return (pref == 0) ? 2'b01 : 2'b10;
        return {src1_valid, src0_valid};
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic logic exp_hazard();
        return mbusy[query_a_addr] | mbusy[query_b_addr];
    endfunction

    // advance the model across one clock edge using the inputs now applied
    task automatic model_update();
        logic [1:0]  g;
        bit          pre [32];
        logic [4:0]  a;
        logic [31:0] d;
        g   = exp_grant();
        pre = mbusy;
        if (reset) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
            pref = 0; mwe = 0; maddr = '0; mdata = '0; merr = 0;
            return;
        end
        if (mwe) mbusy[maddr] = 0;
        if (rsv_valid && !pre[rsv_addr] && rsv_addr != 5'd0) mbusy[rsv_addr] = 1;
        if (g != 2'b00) begin
            a = g[1] ? src1_addr : src0_addr;
            d = g[1] ? src1_data : src0_data;
            if (a != 5'd0 && !pre[a]) merr = 1;
            mwe   = (a != 5'd0);
            maddr = a;
            mdata = d;
            pref  = g[1] ? 0 : 1;
        end else begin
            mwe = 0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsv_valid = 0; rsv_addr = '0;
        src0_valid = 0; src0_addr = '0; src0_data = '0;
        src1_valid = 0; src1_addr = '0; src1_data = '0;
        query_a_addr = '0; query_b_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (gpr_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", gpr_we); end
        checks++; if (busy !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h want=0", busy); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", wb_err); end
        checks++; if (gpr_addr !== 5'd0 || gpr_data !== 32'h0) begin failures++; $display("FAIL reset_port got=%0d/%h want=0/0", gpr_addr, gpr_data); end
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b want=0", hazard); end
    endtask

    task automatic test_reserve_write();
        do_reset();
        rsv_valid = 1; rsv_addr = 5'd6; query_a_addr = 5'd6; #1;
        checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL r6_rsv_ready got=%b want=1", rsv_ready); end
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL r6_hazard_early got=%b want=0", hazard); end
        tick();
        rsv_valid = 0; #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL r6_hazard_set got=%b want=1", hazard); end
        checks++; if (busy !== 32'h40) begin failures++; $display("FAIL r6_busy got=%h want=00000040", busy); end
        tick();
        tick();
        src0_valid = 1; src0_addr = 5'd6; src0_data = 32'h1260_2001; #1;
        checks++; if (src0_ready !== 1'b1 || src1_ready !== 1'b0) begin failures++; $display("FAIL r6_grant got=%b%b want=01", src1_ready, src0_ready); end
        tick();
        src0_valid = 0; #1;
        checks++; if (gpr_we !== 1'b1 || gpr_addr !== 5'd6 || gpr_data !== 32'h1260_2001) begin failures++; $display("FAIL r6_port got=%b/%0d/%h want=1/6/12602001", gpr_we, gpr_addr, gpr_data); end
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL r6_hazard_hold got=%b want=1", hazard); end
        tick();
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL r6_hazard_clear got=%b want=0", hazard); end
        checks++; if (file_mem[6] !== 32'h1260_2001) begin failures++; $display("FAIL r6_file got=%h want=12602001", file_mem[6]); end
        checks++; if (gpr_we !== 1'b0 || wb_err !== 1'b0) begin failures++; $display("FAIL r6_after got=%b/%b want=0/0", gpr_we, wb_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1, last_d;
        logic [4:0]  last_a;
        do_reset();
        rsv_valid = 1; rsv_addr = 5'd9; tick();
        rsv_addr = 5'd10; tick();
        rsv_valid = 0;
        d0 = $urandom; d1 = $urandom; last_a = '0; last_d = '0;
        for (int k = 0; k < 4; k++) begin
            src0_valid = 1; src0_addr = 5'd9;  src0_data = d0;
            src1_valid = 1; src1_addr = 5'd10; src1_data = d1;
            #1;
            checks++; if (src0_ready !== (k % 2 == 0) || src1_ready !== (k % 2 == 1)) begin failures++; $display("FAIL alt_grant_%0d got=%b%b want=%b%b", k, src1_ready, src0_ready, k % 2 == 1, k % 2 == 0); end
            if (k > 0) begin
                checks++; if (gpr_we !== 1'b1 || gpr_addr !== last_a || gpr_data !== last_d) begin failures++; $display("FAIL alt_port_%0d got=%b/%0d/%h want=1/%0d/%h", k, gpr_we, gpr_addr, gpr_data, last_a, last_d); end
            end
            if (k % 2 == 0) begin last_a = 5'd9; last_d = d0; end
            else begin last_a = 5'd10; last_d = d1; end
            tick();
            if (k % 2 == 0) d0 = $urandom; else d1 = $urandom;
        end
        idle(); #1;
        checks++; if (gpr_we !== 1'b1 || gpr_addr !== last_a || gpr_data !== last_d) begin failures++; $display("FAIL alt_port_last got=%b/%0d/%h want=1/%0d/%h", gpr_we, gpr_addr, gpr_data, last_a, last_d); end
        checks++; if (wb_err !== merr) begin failures++; $display("FAIL alt_err got=%b want=%b", wb_err, merr); end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        rsv_valid = 1; rsv_addr = 5'd9; #1;
        checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL waw_first got=%b want=1", rsv_ready); end
        tick();
        #1;
        checks++; if (rsv_ready !== 1'b0) begin failures++; $display("FAIL waw_refuse got=%b want=0", rsv_ready); end
        tick();
        src0_valid = 1; src0_addr = 5'd9; src0_data = 32'hA5A5_0009; #1;
        checks++; if (busy !== 32'h200 || rsv_ready !== 1'b0) begin failures++; $display("FAIL waw_busy got=%h/%b want=00000200/0", busy, rsv_ready); end
        tick();
        src0_valid = 0; #1;
        checks++; if (gpr_we !== 1'b1 || rsv_ready !== 1'b0) begin failures++; $display("FAIL waw_inflight got=%b/%b want=1/0", gpr_we, rsv_ready); end
        tick();
        #1;
        checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL waw_retry got=%b want=1", rsv_ready); end
        tick();
        rsv_valid = 0; query_b_addr = 5'd9; #1;
        checks++; if (busy !== 32'h200 || hazard !== 1'b1) begin failures++; $display("FAIL waw_rebusy got=%h/%b want=00000200/1", busy, hazard); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL waw_err got=%b want=0", wb_err); end
    endtask

    task automatic test_r0_write();
        do_reset();
        rsv_valid = 1; rsv_addr = 5'd3; tick();
        rsv_valid = 0;
        src1_valid = 1; src1_addr = 5'd0; src1_data = 32'hFFFF_FFFF; #1;
        checks++; if (src1_ready !== 1'b1 || src0_ready !== 1'b0) begin failures++; $display("FAIL r0_grant got=%b%b want=10", src1_ready, src0_ready); end
        tick();
        src1_valid = 0; #1;
        checks++; if (gpr_we !== 1'b0) begin failures++; $display("FAIL r0_we got=%b want=0", gpr_we); end
        checks++; if (busy !== 32'h8 || wb_err !== 1'b0) begin failures++; $display("FAIL r0_state got=%h/%b want=00000008/0", busy, wb_err); end
        tick();
        #1;
        checks++; if (busy !== 32'h8 || wb_err !== 1'b0) begin failures++; $display("FAIL r0_state2 got=%h/%b want=00000008/0", busy, wb_err); end
    endtask

    task automatic test_wb_err();
        do_reset();
        src0_valid = 1; src0_addr = 5'd12; src0_data = 32'hC0DE_0012; #1;
        checks++; if (src0_ready !== 1'b1 || wb_err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b/%b want=1/0", src0_ready, wb_err); end
        tick();
        src0_valid = 0; #1;
        checks++; if (wb_err !== 1'b1 || gpr_we !== 1'b1 || gpr_addr !== 5'd12) begin failures++; $display("FAIL err_rise got=%b/%b/%0d want=1/1/12", wb_err, gpr_we, gpr_addr); end
        tick(); tick(); tick();
        #1;
        checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", wb_err); end
        checks++; if (file_mem[12] !== 32'hC0DE_0012) begin failures++; $display("FAIL err_file got=%h want=c0de0012", file_mem[12]); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        rsv_valid = 1; rsv_addr = 5'd28; tick();
        rsv_addr = 5'd31; tick();
        rsv_valid = 0;
        src0_valid = 1; src0_addr = 5'd28; src0_data = 32'h2828_2828; tick();
        src0_valid = 0; reset = 1; #1;
        checks++; if (gpr_we !== 1'b1 || busy !== 32'h9000_0000) begin failures++; $display("FAIL rst_pre got=%b/%h want=1/90000000", gpr_we, busy); end
        tick();
        reset = 0; #1;
        checks++; if (gpr_we !== 1'b0 || busy !== 32'h0 || wb_err !== 1'b0) begin failures++; $display("FAIL rst_clear got=%b/%h/%b want=0/0/0", gpr_we, busy, wb_err); end
        src0_valid = 1; src0_addr = 5'd5; src1_valid = 1; src1_addr = 5'd7; #1;
        checks++; if (src0_ready !== 1'b1 || src1_ready !== 1'b0) begin failures++; $display("FAIL rst_ptr got=%b%b want=01", src1_ready, src0_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] g;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            rsv_valid = $urandom_range(0, 1);
            rsv_addr = 5'($urandom_range(0, 7));
            if (!src0_valid && $urandom_range(0, 2) != 0) begin
                src0_valid = 1; src0_addr = 5'($urandom_range(0, 7)); src0_data = $urandom;
            end
            if (!src1_valid && $urandom_range(0, 2) != 0) begin
                src1_valid = 1; src1_addr = 5'($urandom_range(0, 7)); src1_data = $urandom;
            end
            query_a_addr = 5'($urandom_range(0, 7));
            query_b_addr = 5'($urandom_range(0, 31));
            #1;
            g = exp_grant();
            checks++; if ({src1_ready, src0_ready} !== g) begin failures++; $display("FAIL rnd_grant n=%0d got=%b%b want=%b", n, src1_ready, src0_ready, g); end
            checks++; if (rsv_ready !== !mbusy[rsv_addr]) begin failures++; $display("FAIL rnd_rsv n=%0d got=%b want=%b", n, rsv_ready, !mbusy[rsv_addr]); end
            checks++; if (hazard !== exp_hazard()) begin failures++; $display("FAIL rnd_hazard n=%0d got=%b want=%b", n, hazard, exp_hazard()); end
            checks++; if (busy !== exp_busy()) begin failures++; $display("FAIL rnd_busy n=%0d got=%h want=%h", n, busy, exp_busy()); end
            checks++; if (gpr_we !== mwe) begin failures++; $display("FAIL rnd_we n=%0d got=%b want=%b", n, gpr_we, mwe); end
            if (mwe) begin
                checks++; if (gpr_addr !== maddr || gpr_data !== mdata) begin failures++; $display("FAIL rnd_port n=%0d got=%0d/%h want=%0d/%h", n, gpr_addr, gpr_data, maddr, mdata); end
            end
            checks++; if (wb_err !== merr) begin failures++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, wb_err, merr); end
            tick();
            // a granted source drops or presents a fresh request; a held-off one stays put
            if (g[0]) src0_valid = 0;
            if (g[1]) src1_valid = 0;
        end
        reset = 0;
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_reserve_write();
        test_back_to_back();
        test_waw();
        test_r0_write();
        test_wb_err();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
